// File: rtl/spi_master_ctrl_if.sv
// Host request/response and SPI wire bundle for spi_master_ctrl; master = controller side.
interface spi_master_ctrl_if;
  logic       start;
  logic [9:0] cmd;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       err;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, cmd, MISO,
    output busy, done, rd_data, rd_valid, err, SS_n, MOSI
  );

  modport slave (
    output start, cmd, MISO,
    input  busy, done, rd_data, rd_valid, err, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises 10-bit RAM commands (mode bit + cmd, MSB first) and captures read-data bytes.
// Requests are taken only while busy=0; SPI_MASTER_SEQ_CHK_EN adds a sticky read-sequencing error flag.
module spi_master_ctrl #(
  parameter int unsigned MISO_LAT = 2,
  parameter int unsigned GAP_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_ctrl_if.master bus
);

  localparam int unsigned   CW       = ($clog2(GAP_CYC) > 4) ? $clog2(GAP_CYC) : 4;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] SH_LAST  = CW'(9);
  localparam logic [CW-1:0] RX_LAST  = CW'(7);
  localparam logic [CW-1:0] LAT_LAST = CW'(MISO_LAT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, CMD_BIT, SHIFT, RD_WAIT, RECV, GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    cmd_q, cmd_d;
  logic [6:0]    sh_q, sh_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          ss_n_q, ss_n_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_valid_q, rd_valid_d;
  logic          accept;
`ifdef SPI_MASTER_SEQ_CHK_EN
  logic          err_q, err_d;
  logic          seen_q, seen_d;
`endif

  always_comb begin
    accept    = bus.start && !busy_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    sh_d      = sh_q;
    rd_data_d = rd_data_q;
    if (accept) begin
      cmd_d = bus.cmd;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CMD_BIT;
          cnt_d   = '0;
        end
      end
      CMD_BIT: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        if (cnt_q == SH_LAST) begin
          cnt_d = '0;
          if (cmd_q[9:8] == 2'b11) begin
            state_d = (MISO_LAT == 0) ? RECV : RD_WAIT;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = RECV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RECV: begin
        sh_d = {sh_q[5:0], bus.MISO};
        if (cnt_q == RX_LAST) begin
          rd_data_d = {sh_q, bus.MISO};
          state_d   = GAP;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      GAP: begin
        // busy is already low in the final gap cycle, so a waiting request chains with no idle cycle
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = accept ? CMD_BIT : IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from the next state so they register alongside it
    ss_n_d = (state_d == IDLE) || (state_d == GAP);
    mosi_d = 1'b0;
    if (state_d == CMD_BIT) begin
      mosi_d = cmd_d[9];
    end else if (state_d == SHIFT) begin
      mosi_d = cmd_d[4'd9 - cnt_d[3:0]];
    end
    busy_d     = !((state_d == IDLE) || ((state_d == GAP) && (cnt_d == GAP_LAST)));
    done_d     = (state_d == GAP) && (state_q != GAP);
    rd_valid_d = done_d && (cmd_q[9:8] == 2'b11);

`ifdef SPI_MASTER_SEQ_CHK_EN
    err_d  = err_q;
    seen_d = seen_q;
    if (accept) begin
      if (bus.cmd[9:8] == 2'b11) begin
        if (!seen_q) begin
          err_d = 1'b1;
        end
        seen_d = 1'b0;
      end else if (bus.cmd[9:8] == 2'b10) begin
        seen_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      sh_q       <= '0;
      rd_data_q  <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
`ifdef SPI_MASTER_SEQ_CHK_EN
      err_q      <= 1'b0;
      seen_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      sh_q       <= sh_d;
      rd_data_q  <= rd_data_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
`ifdef SPI_MASTER_SEQ_CHK_EN
      err_q      <= err_d;
      seen_q     <= seen_d;
`endif
    end
  end

  assign bus.SS_n     = ss_n_q;
  assign bus.MOSI     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
`ifdef SPI_MASTER_SEQ_CHK_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a wire-level SPI RAM slave model plus frame-level expectations.
module tb_spi_master_ctrl;
  localparam int LAT = 2;
  localparam int GAP = 1;

  logic clk;
  logic rst_n;
  spi_master_ctrl_if bus ();

  spi_master_ctrl #(.MISO_LAT(LAT), .GAP_CYC(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // slave RAM model (not reset by the controller's reset)
  logic [7:0]  ram [256];
  logic [7:0]  waddr = 8'h00;
  logic [7:0]  raddr = 8'h00;

  // frame-level expectations
  bit          in_frame  = 0;
  bit          have_prev = 0;
  bit          gap_held  = 0;
  int          p         = 0;
  int          hi_cnt    = 100;
  int          frames_done = 0;
  int          last_len  = 0;
  logic [10:0] bits      = '0;
  logic [10:0] last_bits = '0;
  logic [9:0]  exp_cmd   = '0;
  logic [7:0]  exp_rd    = '0;
  bit          err_exp   = 0;
  bit          seen_ra   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe(input bit s, input logic [9:0] c, input bit r);
    bit is_rd;
    if (!r) begin
      chk("rst_ss_n", bus.SS_n, 1);
      chk("rst_mosi", bus.MOSI, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_err", bus.err, 0);
      in_frame = 0; have_prev = 0; hi_cnt = 100;
      exp_rd = '0; err_exp = 0; seen_ra = 0;
      bus.MISO = 1'b0;
      return;
    end
    if (bus.SS_n === 1'b0) begin
      if (!in_frame) begin
        gap_held = gap_held && s;
        chk("accept_start", s, 1);
        if (have_prev) chk("gap_min", hi_cnt >= GAP, 1);
        if (have_prev && gap_held) chk("gap_len", hi_cnt, GAP);
        in_frame = 1; p = 0; bits = '0; exp_cmd = c;
`ifdef SPI_MASTER_SEQ_CHK_EN
        if (c[9:8] == 2'b11) begin
          if (!seen_ra) err_exp = 1;
          seen_ra = 0;
        end else if (c[9:8] == 2'b10) begin
          seen_ra = 1;
        end
`endif
      end
      chk("busy_in_frame", bus.busy, 1);
      chk("done_in_frame", bus.done, 0);
      chk("rdv_in_frame", bus.rd_valid, 0);
      if (p < 11) bits = {bits[9:0], bus.MOSI};
      else chk("mosi_tail", bus.MOSI, 0);
      if (exp_cmd[9:8] == 2'b11 && p >= 11 + LAT && p < 19 + LAT)
        bus.MISO = ram[raddr][18 + LAT - p];
      else
        bus.MISO = 1'($urandom_range(0, 1));
      p++;
    end else begin
      bus.MISO = 1'b0;
      chk("mosi_idle", bus.MOSI, 0);
      if (in_frame) begin
        is_rd = (exp_cmd[9:8] == 2'b11);
        chk("done", bus.done, 1);
        chk("rd_valid", bus.rd_valid, is_rd);
        chk("ss_low_len", p, is_rd ? 19 + LAT : 11);
        chk("mosi_bits", bits, {exp_cmd[9], exp_cmd});
        case (exp_cmd[9:8])
          2'b00: waddr = exp_cmd[7:0];
          2'b01: ram[waddr] = exp_cmd[7:0];
          2'b10: raddr = exp_cmd[7:0];
          default: exp_rd = ram[raddr];
        endcase
        last_bits = bits; last_len = p; frames_done++;
        in_frame = 0; have_prev = 1; hi_cnt = 1; gap_held = 1;
      end else begin
        chk("done_idle", bus.done, 0);
        chk("rdv_idle", bus.rd_valid, 0);
        gap_held = gap_held && s;
        hi_cnt++;
        if (hi_cnt > GAP) chk("busy_idle", bus.busy, 0);
      end
    end
    chk("rd_data", bus.rd_data, exp_rd);
    chk("err", bus.err, err_exp);
  endtask

  task automatic step(input bit s, input logic [9:0] c, input bit r);
    bus.start = s;
    bus.cmd   = c;
    rst_n     = r;
    @(posedge clk);
    #1;
    observe(s, c, r);
  endtask

  task automatic run_frame(input logic [9:0] c);
    step(1, c, 1);
    repeat (19 + LAT + GAP + 1) step(0, 10'($urandom), 1);
  endtask

  int f0;
  int n;
  logic [9:0] rc;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    bus.start = 0; bus.cmd = '0; bus.MISO = 0; rst_n = 0;

    // reset with start asserted, then idle
    repeat (3) step(1, 10'($urandom), 0);
    repeat (4) step(0, '0, 1);

    // example write-addr frame
    f0 = frames_done;
    run_frame(10'b00_1010_0101);
    chk("ex_frames", frames_done - f0, 1);
    chk("ex_bits", last_bits, 11'b000_1010_0101);
    chk("ex_len", last_len, 11);

    // RAM round trip
    run_frame({2'b00, 8'h0F});
    run_frame({2'b01, 8'hC3});
    run_frame({2'b10, 8'h0F});
    run_frame({2'b11, 8'h00});
    chk("ram_rd_data", bus.rd_data, 8'hC3);
    chk("ram_rd_len", last_len, 21);

    // start held with changing cmd
    f0 = frames_done;
    repeat (30) step(1, 10'($urandom), 1);
    repeat (25) step(0, '0, 1);
    chk("held_frames", (frames_done - f0) >= 2, 1);

    // randomized frames with random spacing
    for (int k = 0; k < 12; k++) begin
      rc = 10'($urandom);
      n  = 19 + LAT + GAP + $urandom_range(0, 3);
      step(1, rc, 1);
      repeat (n) step(0, 10'($urandom), 1);
    end

    // reset during the 5th SHIFT bit
    f0 = frames_done;
    step(1, {2'b01, 8'h5A}, 1);
    repeat (5) step(0, '0, 1);
    step(0, '0, 0);
    repeat (2) step(0, '0, 1);
    chk("abort_no_done", frames_done - f0, 0);
    run_frame({2'b00, 8'h33});
    chk("after_abort", frames_done - f0, 1);

    // read-data issued first after reset
    repeat (2) step(0, '0, 0);
    run_frame({2'b11, 8'h00});
`ifdef SPI_MASTER_SEQ_CHK_EN
    chk("seq_err_set", bus.err, 1);
`else
    chk("seq_err_off", bus.err, 0);
`endif
    run_frame({2'b10, 8'h0F});
    run_frame({2'b11, 8'h00});
`ifdef SPI_MASTER_SEQ_CHK_EN
    chk("seq_err_sticky", bus.err, 1);
`else
    chk("seq_err_off2", bus.err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
